fp_norm_pack: RTL and testbench

- Output-side partner of the mantissa add/sub stage.
- Takes the raw result from that stage: sign, 25-bit unnormalised mantissa (carry bit, hidden bit, 23 fraction bits) and the aligned exponent.
- Normalises iteratively, one shift per cycle, and packs an IEEE-754 single-precision word.
- Uses a START/done handshake so the FP datapath controller can sequence it.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_pack.sv | 49 ++++
 rtl/fp_norm_pack.sv | 168 ++++++++++++++++
 tb/tb_fp_norm_pack.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the single-precision normalise/pack path.
//   EXP_W / FRAC_W / BIAS : IEEE-754 single-precision field geometry
//   EXP_MAX               : all-ones exponent field (infinity / NaN)
//   fp32_t                : packed {sign, exp, frac} word
//   norm_state_t          : IDLE / NORM / DONE controller states
//   pack_rule_t           : which packing rule the normaliser settled on
//   POS_ZERO, INF_MAG     : +0 word and infinity magnitude (exp+frac)
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  typedef enum logic [1:0] {
    RULE_NORMAL = 2'd0,
    RULE_ZERO   = 2'd1,
    RULE_OVF    = 2'd2,
    RULE_DENORM = 2'd3
  } pack_rule_t;

  localparam fp32_t POS_ZERO = '{sign: 1'b0, exp: '0, frac: '0};
  localparam logic [EXP_W+FRAC_W-1:0] INF_MAG = {EXP_MAX, {FRAC_W{1'b0}}};

endpackage

// File: rtl/fp_pack.sv
// -----------------------------------------------------------------------------
// fp_pack
// Combinational packer: turns a normalised (or classified) sign/exponent/
// fraction into an IEEE-754 single-precision word plus status flags.
// Shared between the add/sub normaliser and the multiply path.
//   sign      in  : result sign
//   exp       in  : biased exponent field (already range-checked)
//   frac      in  : 23 fraction bits
//   rule      in  : packing rule chosen by the normaliser
//   word      out : packed float
//   zero      out : word is +0
//   overflow  out : word saturated to signed infinity
//   underflow out : word is a denormal with nonzero fraction
// -----------------------------------------------------------------------------
module fp_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  input  pack_rule_t        rule,
  output fp32_t             word,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    word      = POS_ZERO;
    zero      = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    unique case (rule)
      RULE_ZERO: zero = 1'b1;  // sign is dropped: cancellation yields +0
      RULE_OVF: begin
        word     = {sign, INF_MAG};
        overflow = 1'b1;
      end
      RULE_DENORM: begin
        word      = {sign, {EXP_W{1'b0}}, frac};
        underflow = |frac;
      end
      default: word = {sign, exp, frac};
    endcase
  end

endmodule

// File: rtl/fp_norm_pack.sv
// -----------------------------------------------------------------------------
// fp_norm_pack
// Output stage of the FP add/sub datapath. Takes the raw sign, aligned
// exponent and 25-bit mantissa {carry, hidden, frac[22:0]}, normalises it one
// shift per cycle and packs a single-precision word. START/done handshake.
//   CLK, RST_N : clock, asynchronous active-low reset
//   START      : one-cycle request, honoured only when idle
//   SIGN_IN    : result sign
//   EXP_IN     : biased exponent of the aligned operands
//   MANT_IN    : bit 24 carry, bit 23 hidden, bits 22:0 fraction
//   result     : packed {sign, exp, frac}, held until the next completion
//   done       : one-cycle pulse when result/flags update
//   busy       : high while an operation is in flight
//   zero / overflow / underflow : status of result, held with it
// Build option: define FP_ROUND_EN to round-half-even on the bit lost by the
// carry right shift; otherwise that bit is truncated.
// -----------------------------------------------------------------------------
module fp_norm_pack
  import fp_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              SIGN_IN,
  input  logic [EXP_W-1:0]  EXP_IN,
  input  logic [FRAC_W+1:0] MANT_IN,
  output logic [31:0]       result,
  output logic              done,
  output logic              busy,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  norm_state_t       state;
  pack_rule_t        rule_r;
  logic              s_r;
  logic [EXP_W:0]    e_r;   // one bit of headroom for the carry increment
  logic [FRAC_W+1:0] m_r;
  logic [FRAC_W-1:0] frac_pack;

  fp32_t pack_word;
  logic  pack_zero, pack_ovf, pack_unf;

`ifdef FP_ROUND_EN
  logic              rbit;  // bit shifted out by the carry right shift
  logic [FRAC_W+1:0] m_rnd;
  logic              rnd_carry;

  // Only one bit can ever be shifted out, so rbit=1 is an exact tie:
  // round up only when that makes the result even.
  always_comb begin
    m_rnd = m_r;
    if (rule_r == RULE_NORMAL && rbit && m_r[0])
      m_rnd = {1'b0, m_r[FRAC_W:0]} + (FRAC_W+2)'(1);
    rnd_carry = m_rnd[FRAC_W+1];
    frac_pack = m_rnd[FRAC_W-1:0];
  end
`else
  assign frac_pack = m_r[FRAC_W-1:0];
`endif

  fp_pack u_pack (
    .sign      (s_r),
    .exp       (e_r[EXP_W-1:0]),
    .frac      (frac_pack),
    .rule      (rule_r),
    .word      (pack_word),
    .zero      (pack_zero),
    .overflow  (pack_ovf),
    .underflow (pack_unf)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // NOTE: only flops, no memories, so every register is cleared by the
  // asynchronous reset; a mid-operation reset aborts without a done pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rule_r    <= RULE_NORMAL;
      s_r       <= 1'b0;
      e_r       <= '0;
      m_r       <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef FP_ROUND_EN
      rbit      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            s_r       <= SIGN_IN;
            e_r       <= {1'b0, EXP_IN};
            m_r       <= MANT_IN;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            busy      <= 1'b1;
            state     <= NORM;
`ifdef FP_ROUND_EN
            rbit      <= 1'b0;
`endif
          end
        end

        NORM: begin
          if (m_r == '0) begin
            rule_r <= RULE_ZERO;
            state  <= DONE;
          end else if (m_r[FRAC_W+1]) begin
            m_r <= m_r >> 1;
            e_r <= e_r + 1'b1;
`ifdef FP_ROUND_EN
            rbit <= m_r[0];
`endif
          end else if (e_r >= {1'b0, EXP_MAX}) begin
            rule_r <= RULE_OVF;
            state  <= DONE;
          end else if (!m_r[FRAC_W] && e_r > 9'd1) begin
            m_r <= m_r << 1;
            e_r <= e_r - 1'b1;
          end else if (!m_r[FRAC_W]) begin
            rule_r <= RULE_DENORM;
            state  <= DONE;
          end else begin
            rule_r <= RULE_NORMAL;
            state  <= DONE;
          end
        end

        DONE: begin
`ifdef FP_ROUND_EN
          // Rounding carried into bit 24: spend one cycle re-normalising.
          // rbit is cleared so the word is not rounded a second time.
          if (rnd_carry) begin
            m_r  <= m_rnd >> 1;
            e_r  <= e_r + 1'b1;
            rbit <= 1'b0;
            if ((e_r + 1'b1) >= {1'b0, EXP_MAX}) rule_r <= RULE_OVF;
          end else
`endif
          begin
            result    <= pack_word;
            zero      <= pack_zero;
            overflow  <= pack_ovf;
            underflow <= pack_unf;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_norm_pack
// Directed self-checking bench for fp_norm_pack. Inputs are driven on the
// falling edge, outputs sampled on the falling edge. Latency is the number of
// rising edges after the START-sampling edge until done is seen high.
// Expected values for the rounding vectors depend on FP_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_fp_norm_pack;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic        SIGN_IN;
  logic [7:0]  EXP_IN;
  logic [24:0] MANT_IN;
  logic [31:0] result;
  logic        done, busy, zero, overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  fp_norm_pack dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .SIGN_IN   (SIGN_IN),
    .EXP_IN    (EXP_IN),
    .MANT_IN   (MANT_IN),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .zero      (zero),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done. With poke set, START is
  // toggled with junk operands on every busy cycle; those must be ignored.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input bit poke, output int lat, output bit busy_ok);
    @(negedge CLK);
    SIGN_IN = s; EXP_IN = e; MANT_IN = m; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke) begin
        START = ~START; SIGN_IN = 1'b1; EXP_IN = 8'h11; MANT_IN = 25'h1000000;
      end
      @(negedge CLK);
      lat++;
      if (done === 1'b1) break;
    end
    START = 1'b0;
  endtask

  int       lat;
  bit       bok;
  logic [2:0] flags;
  bit       saw_done;

  assign flags = {zero, overflow, underflow};

  initial begin
    RST_N = 1'b0; START = 1'b0; SIGN_IN = 1'b0; EXP_IN = '0; MANT_IN = '0;
    repeat (2) @(negedge CLK);
    check("reset_result", result, 32'h0);
    check("reset_ctrl",   {29'd0, done, busy, 1'b0}, 32'h0);
    check("reset_flags",  {29'd0, flags}, 32'h0);
    RST_N = 1'b1;

    // Already normalised: 3.0
    run_op(1'b0, 8'h80, 25'h0C00000, 1'b0, lat, bok);
    check("norm_lat",    lat, 2);
    check("norm_result", result, 32'h40400000);
    check("norm_flags",  {29'd0, flags}, 32'h0);
    check("norm_busy",   {31'd0, busy}, 32'h0);
    @(negedge CLK);
    check("done_pulse",  {31'd0, done}, 32'h0);
    check("result_hold", result, 32'h40400000);

    // Carry out of the adder: one right shift
    run_op(1'b0, 8'h7F, 25'h1000000, 1'b0, lat, bok);
    check("carry_lat",    lat, 3);
    check("carry_result", result, 32'h40000000);

    // Zero mantissa: +0 regardless of sign
    run_op(1'b1, 8'h85, 25'h0000000, 1'b0, lat, bok);
    check("zero_lat",    lat, 2);
    check("zero_result", result, 32'h00000000);
    check("zero_flags",  {29'd0, flags}, 32'h4);

    // Carry pushes exponent to 255: saturate to -inf
    run_op(1'b1, 8'hFE, 25'h1000000, 1'b0, lat, bok);
    check("ovf_lat",    lat, 3);
    check("ovf_result", result, 32'hFF800000);
    check("ovf_flags",  {29'd0, flags}, 32'h2);
    repeat (3) @(negedge CLK);
    check("ovf_hold",   {29'd0, flags}, 32'h2);

    // Massive cancellation: 23 left shifts, START pokes ignored
    run_op(1'b0, 8'h7F, 25'h0000001, 1'b1, lat, bok);
    check("cancel_lat",    lat, 25);
    check("cancel_result", result, 32'h34000000);
    check("cancel_busy",   {31'd0, bok}, 32'h1);
    check("cancel_flags",  {29'd0, flags}, 32'h0);
    repeat (3) @(negedge CLK);
    check("poke_no_queue", {30'd0, done, busy}, 32'h0);

    // Exponent already 0, hidden bit clear: denormal with no shifts
    run_op(1'b0, 8'h00, 25'h0400000, 1'b0, lat, bok);
    check("denorm0_lat",    lat, 2);
    check("denorm0_result", result, 32'h00400000);
    check("denorm0_flags",  {29'd0, flags}, 32'h1);

    // One left shift brings exponent to 1, then denormal
    run_op(1'b1, 8'h02, 25'h0200000, 1'b0, lat, bok);
    check("denorm1_lat",    lat, 3);
    check("denorm1_result", result, 32'h80400000);

    // Tie on the shifted-out bit, odd LSB
    run_op(1'b0, 8'h7F, 25'h1000003, 1'b0, lat, bok);
    check("round_lat", lat, 3);
`ifdef FP_ROUND_EN
    check("round_result", result, 32'h40000002);
`else
    check("round_result", result, 32'h40000001);
`endif

    // Rounding carries into bit 24: one extra renormalisation cycle
    run_op(1'b0, 8'h7F, 25'h1FFFFFF, 1'b0, lat, bok);
`ifdef FP_ROUND_EN
    check("rcarry_lat",    lat, 4);
    check("rcarry_result", result, 32'h40800000);
`else
    check("rcarry_lat",    lat, 3);
    check("rcarry_result", result, 32'h407FFFFF);
`endif

    // Reset in the middle of a long cancellation
    @(negedge CLK);
    SIGN_IN = 1'b0; EXP_IN = 8'h7F; MANT_IN = 25'h0000001; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    check("pre_reset_busy", {31'd0, busy}, 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_ctrl",   {30'd0, done, busy}, 32'h0);
    check("rst_mid_flags",  {29'd0, flags}, 32'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (done === 1'b1) saw_done = 1'b1;
    end
    RST_N = 1'b1;
    repeat (30) begin
      @(negedge CLK);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("rst_no_done", {31'd0, saw_done}, 32'h0);

    run_op(1'b0, 8'h80, 25'h0C00000, 1'b0, lat, bok);
    check("post_rst_lat",    lat, 2);
    check("post_rst_result", result, 32'h40400000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
